// File: rtl/keypad_pkg.sv
// Shared types, constants and the column decoder for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROW_W = 2;
    localparam int unsigned COL_W = 2;

    localparam logic [COLS-1:0] COLS_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    typedef struct packed {
        logic             single;
        logic [COL_W-1:0] idx;
    } col_dec_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_t;

    // Exactly one low column is a key; none or several (ghosting) is no key.
    function automatic col_dec_t col_decode(input logic [COLS-1:0] col);
        col_dec_t d;
        d = '{single: 1'b0, idx: '0};
        case (col)
            4'b1110: d = '{single: 1'b1, idx: 2'd0};
            4'b1101: d = '{single: 1'b1, idx: 2'd1};
            4'b1011: d = '{single: 1'b1, idx: 2'd2};
            4'b0111: d = '{single: 1'b1, idx: 2'd3};
            default: d = '{single: 1'b0, idx: '0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running row-dwell divider; tick is high while the count sits at SCAN_DIV-1.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    // tick is registered one count early so it coincides with the terminal count
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            tick <= (cnt_q == CNT_W'(SCAN_DIV - 2));
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column synchroniser, press/release debounce
// and registered key code with a one-cycle valid strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    logic             tick;
    logic [COLS-1:0]  col_meta;
    logic [COLS-1:0]  col_s;
    col_dec_t         dec;

    state_t           state_q,    state_d;
    logic [ROW_W-1:0] row_idx_q,  row_idx_d;
    logic [COL_W-1:0] cand_q,     cand_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [ROWS-1:0]  row_out_d;
    logic [3:0]       key_code_d;
    logic             key_valid_d;
    logic             key_held_d;
    logic             accept;
    key_t             key_new;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    // Column lines are asynchronous to clk.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            col_meta <= COLS_IDLE;
            col_s    <= COLS_IDLE;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    assign dec     = col_decode(col_s);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= SCAN;
            row_idx_q <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            row_out   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            row_out   <= row_out_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_held_d  = key_held;
        accept      = 1'b0;
        key_new     = '{row: row_idx_q, col: cand_q};

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (dec.single) begin
                        cand_d = dec.idx;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + ROW_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (dec.single && (dec.idx == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                            accept = 1'b1;
                        end
                    end else begin
                        cnt_d     = '0;
                        row_idx_d = row_idx_q + ROW_W'(1);
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    // Any low column restarts the release count; no new key is reported here.
                    if (col_s == COLS_IDLE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            row_idx_d  = row_idx_q + ROW_W'(1);
                            state_d    = SCAN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end

        if (accept) begin
            key_new     = '{row: row_idx_q, col: cand_d};
            key_code_d  = key_new;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = '0;
            state_d     = HELD;
        end

        row_out_d = ~(ROWS'(1) << row_idx_d);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    logic       clk;
    logic       clr;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    int          checks;
    int          failures;
    logic        mon_en;
    logic        valid_prev;
    logic        sweep_en;
    logic [3:0]  seen_rows;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        pressed[r*4+c] = 1'b1;
    endtask

    task automatic unpress(input int r, input int c);
        pressed[r*4+c] = 1'b0;
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        cycles(1);
        check(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic wait_release(output int n, input int budget);
        n = 0;
        while (key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Output monitor: pop the scoreboard on every strobe and police the row drive.
    always @(negedge clk) begin
        if (mon_en) begin
            check("row_onecold", 32'($countones(~row_out)), 1);
            if (sweep_en) seen_rows <= seen_rows | ~row_out;
            if (key_valid) begin
                if (valid_prev) check("valid_width", 32'(valid_prev), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(key_valid), 0);
                end else begin
                    check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
                    check("held_at_valid", 32'(key_held), 1);
                end
            end
            valid_prev <= key_valid;
        end
    end

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        mon_en     = 1'b0;
        valid_prev = 1'b0;
        sweep_en   = 1'b0;
        seen_rows  = 4'h0;
        pressed    = 16'h0;
        clr        = 1'b1;

        cycles(3);
        check("rst_row_out", 32'(row_out), 32'h0000_000e);
        check("rst_key_code", 32'(key_code), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_held", 32'(key_held), 0);
        clr    = 1'b0;
        mon_en = 1'b1;
        cycles(10);

        // Clean press of (2,1), then clean release.
        exp_q.push_back(4'h9);
        press(2, 1);
        wait_drained("press_2_1", 40);
        cycles(200);
        check("held_2_1", 32'(key_held), 1);
        unpress(2, 1);
        wait_release(n, 40);
        check("release_window", 32'((n >= 9) && (n <= 16)), 1);
        check("resume_row", 32'(row_out), 32'h0000_0007);
        check("code_kept", 32'(key_code), 32'h9);
        cycles(10);

        // Bouncing (1,3): two ticks down, one tick up, five times.
        seen_rows = 4'h0;
        sweep_en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            press(1, 3);
            cycles(8);
            unpress(1, 3);
            cycles(4);
        end
        sweep_en = 1'b0;
        cycles(20);
        check("bounce_sweep", 32'(seen_rows), 32'hf);
        check("bounce_no_held", 32'(key_held), 0);

        // Ghosting on row 0, then resolve to a single key.
        press(0, 0);
        press(0, 2);
        cycles(100);
        check("ghost_no_held", 32'(key_held), 0);
        exp_q.push_back(4'h0);
        unpress(0, 2);
        wait_drained("ghost_resolve", 40);
        unpress(0, 0);
        wait_release(n, 40);
        check("ghost_release", 32'(key_held), 0);
        cycles(10);

        // (3,2) with a bouncy release, then a second press.
        exp_q.push_back(4'hE);
        press(3, 2);
        wait_drained("press_3_2", 40);
        cycles(40);
        unpress(3, 2);
        cycles(4);
        press(3, 2);
        cycles(4);
        check("rel_bounce_held", 32'(key_held), 1);
        unpress(3, 2);
        cycles(6);
        check("rel_early_held", 32'(key_held), 1);
        wait_release(n, 30);
        check("rel_final", 32'(key_held), 0);
        check("code_kept_e", 32'(key_code), 32'he);
        cycles(10);
        exp_q.push_back(4'hE);
        press(3, 2);
        wait_drained("repress_3_2", 40);
        unpress(3, 2);
        wait_release(n, 40);
        cycles(10);

        // Asynchronous clear while HELD, then rescan with the key still down.
        exp_q.push_back(4'h9);
        press(2, 1);
        wait_drained("press_2_1_b", 40);
        cycles(20);
        check("held_before_clr", 32'(key_held), 1);
        #2 clr = 1'b1;
        #1;
        check("clr_row_out", 32'(row_out), 32'h0000_000e);
        check("clr_key_code", 32'(key_code), 0);
        check("clr_key_valid", 32'(key_valid), 0);
        check("clr_key_held", 32'(key_held), 0);
        cycles(3);
        clr = 1'b0;
        exp_q.push_back(4'h9);
        wait_drained("press_after_clr", 40);
        cycles(5);
        check("held_after_clr", 32'(key_held), 1);
        unpress(2, 1);
        wait_release(n, 40);
        check("release_after_clr", 32'(key_held), 0);
        cycles(10);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one keypad row low at a time and samples the four column lines.
- Debounces press and release at scan-tick granularity.
- Reports each debounced press as a 4-bit key code with a one-cycle valid strobe.
- Output feeds the display data path and control logic on the board clock domain.

Parameters:
SCAN_DIV, 16'd50000, clk cycles per scan tick (row dwell time); minimum legal value is 4.
DEBOUNCE_CNT, 4, consecutive matching scan ticks required to accept a press or a release; minimum 1.

Ports:
clk  input  1  system clock; the single clock of the block.
clr  input  1  reset, asynchronous, active-high.
col_in  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk.
row_out  output  4  row drive, active-low, exactly one bit low at all times.
key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
key_valid  output  1  one-cycle pulse when a new press is accepted.
key_held  output  1  high while an accepted key is still down (until release is debounced).

Behaviour:
- Clock and reset: already decided, one clock `clk`, reset `clr` asynchronous and active-high. All flops clear on `clr` regardless of `clk`.
- Reset values:
  - row_out=4'b1110 (row 0), key_code=4'h0, key_valid=0, key_held=0.
  - state=SCAN, row_idx=0, tick counter=0, debounce counter=0, synchroniser flops=4'b1111.
- Synchroniser: col_in passes through a 2-flop synchroniser; all decisions use the synchronised value col_s.
- Scan tick:
  - Free-running counter 0..SCAN_DIV-1; tick is a one-cycle pulse when the count equals SCAN_DIV-1, then the counter wraps to 0.
  - All state decisions happen on tick cycles only.
- row_out: row_out = ~(4'b0001 << row_idx). row_idx advances (wrapping 3->0) only on a tick in SCAN with no valid candidate, or on a failed DEBOUNCE.
- "Single key": col_s has exactly one zero bit. col_idx is the index of that zero bit. Zero, two or more zeros count as no key (ghosting is rejected).
- State SCAN:
  - On tick with a single key: latch cand_col=col_idx, keep row_idx, set debounce count=1.
  - If DEBOUNCE_CNT==1, accept immediately as in DEBOUNCE; otherwise go to DEBOUNCE.
  - On tick otherwise: advance row_idx.
- State DEBOUNCE (row frozen):
  - On tick with a single key and col_idx==cand_col: count++. When count reaches DEBOUNCE_CNT, accept.
  - On tick otherwise: count=0, advance row_idx, go to SCAN.
- Accept:
  - key_code <= {row_idx, cand_col}; key_valid=1 for exactly the cycle after the accepting tick; key_held<=1.
  - Release counter=0; go to HELD.
- State HELD (row frozen):
  - On tick with col_s==4'b1111: release count++. When it reaches DEBOUNCE_CNT: key_held<=0, count=0, advance row_idx, go to SCAN.
  - On tick with any zero bit in col_s: release count=0.
  - No further key_valid while HELD, even if a different column goes low on the same row.
- key_code holds its value until the next accept. It is not cleared on release.
- Worst-case press latency: 4*SCAN_DIV + DEBOUNCE_CNT*SCAN_DIV + 3 cycles (full row sweep, debounce, synchroniser, output register).
- clr mid-operation (any state): immediate return to reset values. A pending press is discarded and no key_valid is emitted.

Decomposition:
- Shared package keypad_pkg:
  - State encoding SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2.
  - Constants ROWS=4, COLS=4, COLS_IDLE=4'b1111.
  - One-hot-zero-to-index function used for col_idx and the single-key check.
- One sub-module, scan_tick_gen: parameterised by SCAN_DIV, ports clk, clr, tick. The top level contains the synchroniser, FSM and output registers.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3; keypad model pulls col c low while row_out[r]==0 and key (r,c) is pressed):
- Reset: assert clr mid-cycle -> row_out=4'b1110, key_code=0, key_valid=0, key_held=0 immediately, with no clk edge needed.
- Clean press of key (2,1) held for 200 cycles -> exactly one key_valid pulse, key_code=4'h9, key_held=1. Release -> key_held falls 3 ticks (12 cycles) +/-2 cycles after col_s returns to 4'b1111; row scanning resumes.
- Bounce: (1,3) pressed for 2 ticks, released 1 tick, repeated 5 times -> no key_valid; row_out keeps sweeping 1110,1101,1011,0111.
- Ghosting: (0,0) and (0,2) pressed together -> no key_valid. Release (0,2) only -> key_valid with key_code=4'h0.
- Release bounce then re-press: hold (3,2) -> one pulse, code 4'hE. Release with 1-tick bounce -> key_held stays 1 until 3 clean idle ticks. Press (3,2) again -> second pulse, code 4'hE.
- clr asserted while in HELD with (2,1) pressed -> all outputs at reset values. After clr deasserts with the key still down -> a fresh key_valid with code 4'h9 after re-scan and debounce.
